// File: rtl/param_interrupt_controller.sv
// rtl/param_interrupt_controller.sv - rotating-priority, fully nested interrupt controller
// with a register port and a three-state CPU acknowledge handshake.
module param_interrupt_controller #(
  parameter int NUM_IRQ = 16,
  parameter int ID_W    = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               chip_select_n,
  input  logic               write_enable_n,
  input  logic               read_enable_n,
  input  logic [2:0]         address,
  input  logic [31:0]        data_bus_in,
  output logic [31:0]        data_bus_out,
  input  logic [NUM_IRQ-1:0] interrupt_request,
  output logic               interrupt_to_cpu,
  input  logic               interrupt_acknowledge_n,
  output logic [7:0]         vector_out,
  output logic               vector_valid
);

  if (NUM_IRQ < 2 || NUM_IRQ > 32 || NUM_IRQ > (1 << ID_W)) begin : g_bad_params
    $error("param_interrupt_controller: NUM_IRQ must be 2..32 and fit in ID_W bits");
  end

  typedef enum logic [1:0] {IDLE, PENDING, VECTOR} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d, trig_q, trig_d, irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d, req_q, req_d;
  logic               auto_eoi_q, auto_eoi_d, rotate_q, rotate_d;
  logic [7:0]         vbase_q, vbase_d;
  logic [ID_W-1:0]    prio_q, prio_d, vec_id_q, vec_id_d;
  logic               vec_real_q, vec_real_d;

  logic [NUM_IRQ-1:0] pend, win_oh, isr_top_oh;
  logic               win_any, isr_any, win_ok;
  logic [ID_W-1:0]    win_id;
  int                 win_rank, isr_rank;

  logic               wr, eoi_wr, auto_clr;
  logic [ID_W-1:0]    eoi_id;
  logic [NUM_IRQ-1:0] eoi_oh, vec_oh, ack_set, eoi_clr, auto_oh, irr_clr, edge_set;
  logic               unused_data;

  assign unused_data = ^data_bus_in;

  // Rank 0 is channel P+1; the lowest rank among pending/in-service bits wins.
  always_comb begin
    int rank;
    rank       = 0;
    pend       = irr_q & ~mask_q;
    win_any    = 1'b0;
    win_id     = '0;
    win_oh     = '0;
    win_rank   = NUM_IRQ;
    isr_any    = 1'b0;
    isr_top_oh = '0;
    isr_rank   = NUM_IRQ;
    for (int i = 0; i < NUM_IRQ; i++) begin
      rank = i + NUM_IRQ - 1 - int'(prio_q);
      if (rank >= NUM_IRQ) rank = rank - NUM_IRQ;
      if (pend[i] && rank < win_rank) begin
        win_any   = 1'b1;
        win_id    = ID_W'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_rank  = rank;
      end
      if (isr_q[i] && rank < isr_rank) begin
        isr_any       = 1'b1;
        isr_top_oh    = '0;
        isr_top_oh[i] = 1'b1;
        isr_rank      = rank;
      end
    end
    win_ok = win_any && (!isr_any || win_rank < isr_rank);
  end

  always_comb begin
    wr         = !chip_select_n && !write_enable_n;
    mask_d     = mask_q;
    trig_d     = trig_q;
    auto_eoi_d = auto_eoi_q;
    rotate_d   = rotate_q;
    vbase_d    = vbase_q;
    req_d      = interrupt_request;
    if (wr) begin
      case (address)
        3'd0: mask_d = data_bus_in[NUM_IRQ-1:0];
        3'd1: trig_d = data_bus_in[NUM_IRQ-1:0];
        3'd4: begin
          auto_eoi_d = data_bus_in[0];
          rotate_d   = data_bus_in[1];
          vbase_d    = data_bus_in[15:8];
        end
        default: ;
      endcase
    end

    eoi_wr = wr && (address == 3'd5);
    eoi_id = data_bus_in[ID_W-1:0];
    eoi_oh = '0;
    vec_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      eoi_oh[i] = (eoi_id == ID_W'(i));
      vec_oh[i] = (vec_id_q == ID_W'(i));
    end

    state_d    = state_q;
    vec_id_d   = vec_id_q;
    vec_real_d = vec_real_q;
    ack_set    = '0;
    auto_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!interrupt_acknowledge_n) begin
          state_d    = VECTOR;
          vec_id_d   = ID_W'(NUM_IRQ - 1);
          vec_real_d = 1'b0;
        end else if (win_ok) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (!interrupt_acknowledge_n) begin
          state_d = VECTOR;
          if (win_ok) begin
            vec_id_d   = win_id;
            vec_real_d = 1'b1;
            ack_set    = win_oh;
          end else begin
            vec_id_d   = ID_W'(NUM_IRQ - 1);
            vec_real_d = 1'b0;
          end
        end else if (!win_ok) begin
          state_d = IDLE;
        end
      end
      VECTOR: begin
        if (interrupt_acknowledge_n) begin
          state_d  = IDLE;
          auto_clr = auto_eoi_q && vec_real_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A spurious vector never owned an ISR bit, so auto-EOI must not touch ISR for it.
    eoi_clr = '0;
    if (eoi_wr) eoi_clr = data_bus_in[8] ? (eoi_oh & isr_q) : isr_top_oh;
    auto_oh = auto_clr ? (vec_oh & isr_q) : '0;
    isr_d   = (isr_q & ~eoi_clr & ~auto_oh) | ack_set;

    prio_d = prio_q;
    if (rotate_q) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (eoi_clr[i]) prio_d = ID_W'(i);
      end
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (auto_oh[i]) prio_d = ID_W'(i);
      end
    end

    edge_set = interrupt_request & ~req_q;
    irr_clr  = (trig_q & ~trig_d) | ack_set;
    for (int i = 0; i < NUM_IRQ; i++) begin
      irr_d[i] = trig_d[i] ? interrupt_request[i] : (edge_set[i] | (irr_q[i] & ~irr_clr[i]));
    end
  end

  always_comb begin
    data_bus_out = '0;
    if (!chip_select_n && !read_enable_n) begin
      case (address)
        3'd0: data_bus_out = 32'(mask_q);
        3'd1: data_bus_out = 32'(trig_q);
        3'd2: data_bus_out = 32'(irr_q);
        3'd3: data_bus_out = 32'(isr_q);
        3'd4: data_bus_out = {16'h0, vbase_q, 6'h0, rotate_q, auto_eoi_q};
        3'd6: data_bus_out = 32'(prio_q);
        default: data_bus_out = '0;
      endcase
    end
  end

  assign interrupt_to_cpu = (state_q == PENDING);
  assign vector_valid     = (state_q == VECTOR);
  assign vector_out       = vector_valid ? (vbase_q + 8'(vec_id_q)) : 8'h0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mask_q     <= '1;
      trig_q     <= '0;
      irr_q      <= '0;
      isr_q      <= '0;
      req_q      <= '0;
      auto_eoi_q <= 1'b0;
      rotate_q   <= 1'b0;
      vbase_q    <= '0;
      prio_q     <= ID_W'(NUM_IRQ - 1);
      vec_id_q   <= '0;
      vec_real_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      trig_q     <= trig_d;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      req_q      <= req_d;
      auto_eoi_q <= auto_eoi_d;
      rotate_q   <= rotate_d;
      vbase_q    <= vbase_d;
      prio_q     <= prio_d;
      vec_id_q   <= vec_id_d;
      vec_real_q <= vec_real_d;
    end
  end

endmodule

// File: doc/param_interrupt_controller.md
PARAM_INTERRUPT_CONTROLLER -- requirements
Module: param_interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 16, number of request channels (legal 2..32).
REQ-002 SHALL have parameter ID_W, default 5, width of a channel id; the design SHALL require NUM_IRQ <= 2**ID_W.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port chip_select_n, input, 1, register access select, active low.
REQ-006 SHALL have port write_enable_n, input, 1, register write strobe, active low.
REQ-007 SHALL have port read_enable_n, input, 1, register read strobe, active low.
REQ-008 SHALL have port address, input, 3, register select.
REQ-009 SHALL have port data_bus_in, input, 32, write data.
REQ-010 SHALL have port data_bus_out, output, 32, read data; unused high bits are 0.
REQ-011 SHALL have port interrupt_request, input, NUM_IRQ, request lines, synchronous to clock.
REQ-012 SHALL have port interrupt_to_cpu, output, 1, registered interrupt to the CPU.
REQ-013 SHALL have port interrupt_acknowledge_n, input, 1, CPU acknowledge, active low.
REQ-014 SHALL have ports vector_out (output, 8) and vector_valid (output, 1), the acknowledge vector and its qualifier.

Function
REQ-015 A register write SHALL occur on any clock edge where chip_select_n=0 and write_enable_n=0.
- addr 0 MASK: RW, 1 = masked.
- addr 1 TRIGGER: RW, 1 = level, 0 = edge.
- addr 2 IRR: RO.
- addr 3 ISR: RO.
- addr 4 CONTROL: RW; bit0 auto_eoi, bit1 rotate_on_eoi, bits15:8 vector_base.
- addr 5 EOI: WO; bit8 specific, bits[ID_W-1:0] id.
- addr 6 PRIORITY: RO; lowest-priority pointer P.
- addr 7: reads 0, writes ignored.
REQ-016 data_bus_out SHALL be combinational from address while chip_select_n=0 and read_enable_n=0, else 0; reads have no side effects.
REQ-017 Edge channel: IRR bit sets on a 0->1 change of interrupt_request versus its value registered on the previous cycle, and clears only when acknowledged. A set SHALL win over a clear in the same cycle.
REQ-018 Level channel: IRR bit SHALL equal the registered interrupt_request bit.
REQ-019 A TRIGGER write SHALL clear the IRR bits of channels switched to edge mode.
REQ-020 Priority SHALL rotate: channel (P+1) mod NUM_IRQ is highest, descending cyclically to P.
REQ-021 Winner SHALL be the highest-priority bit of IRR & ~MASK, and only if it is strictly higher than every set ISR bit (fully nested).
REQ-022 The acknowledge FSM SHALL have states IDLE, PENDING and VECTOR.
- IDLE -> PENDING when a winner exists.
- interrupt_to_cpu = 1 exactly while in PENDING, so its latency is 1 cycle from the IRR update.
REQ-023 In PENDING, if the winner vanishes (masked, level dropped) before acknowledge, the FSM SHALL return to IDLE on the next cycle.
REQ-024 In PENDING, the first cycle with interrupt_acknowledge_n=0 SHALL:
- latch the winner id;
- set its ISR bit;
- clear its IRR bit (edge channels only);
- move the FSM to VECTOR.
REQ-025 In VECTOR, vector_valid SHALL be 1 and vector_out SHALL be (vector_base + id) mod 256. On the first cycle with interrupt_acknowledge_n=1 the FSM SHALL go to IDLE and vector_valid SHALL go to 0.
REQ-026 Spurious acknowledge: if interrupt_acknowledge_n falls in IDLE, or in the same cycle the winner vanishes, the FSM SHALL enter VECTOR with id = NUM_IRQ-1 and SHALL NOT set any ISR bit.
REQ-027 EOI handling:
- non-specific EOI clears the highest-priority set ISR bit;
- specific EOI clears ISR[id];
- EOI with ISR empty, or id >= NUM_IRQ, has no effect.
REQ-028 With auto_eoi=1, the ISR bit SHALL be cleared on the VECTOR->IDLE transition instead of being held.
REQ-029 With rotate_on_eoi=1, any EOI (including auto) that clears ISR[k] SHALL set P := k.
REQ-030 Acknowledge latching SHALL use MASK and P as they were before any write in the same cycle.

Reset
REQ-031 On reset_n=0, asynchronously, the block SHALL set:
- MASK all ones; TRIGGER, IRR, ISR, CONTROL = 0;
- P = NUM_IRQ-1;
- FSM = IDLE;
- interrupt_to_cpu, vector_valid, vector_out = 0;
- registered request copy = 0.
A reset during PENDING or VECTOR SHALL abandon the cycle with no ISR bit set.

Verification
REQ-032 Setup: NUM_IRQ=16; unmask all; vector_base=0x40. Stimulus: pulse request 3, then acknowledge low 2 cycles. Required: interrupt_to_cpu asserted; vector_out=0x43 with vector_valid=1; ISR=0x0008; IRR bit3=0.
REQ-033 Setup: ISR[3] set. Stimulus: raise requests 5 and 1. Required: only channel 1 is acknowledged (vector 0x41). Then non-specific EOI clears ISR[1], and request 5 stays pending.
REQ-034 Setup: rotate_on_eoi=1. Stimulus: acknowledge ch0, then EOI. Required: PRIORITY reads 0. Then simultaneous requests 0 and 1 yield vector 0x41 first.
REQ-035 Setup: level mode ch2. Stimulus: raise ch2 to reach PENDING, drop it, then acknowledge. Required: vector_out=0x4F (spurious); ISR unchanged.
REQ-036 Setup: auto_eoi=1. Stimulus: acknowledge ch7. Required: ISR=0 after acknowledge release. Also: reset_n pulse mid-VECTOR gives all outputs 0 and MASK=0xFFFF.
